// File: rtl/change_dispenser_pkg.sv
// Shared definitions for the change dispenser: FSM encoding, coin values
// and the denomination index used between the selector and the stock logic.
package change_dispenser_pkg;

    // Controller states, 3-bit encoding
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CALC     = 3'd1,
        DISPENSE = 3'd2,
        DONE     = 3'd3,
        ERR      = 3'd4
    } state_t;

    // Coin values in the order they are tried (largest first)
    localparam logic [5:0] COIN_50 = 6'd50;
    localparam logic [5:0] COIN_10 = 6'd10;
    localparam logic [5:0] COIN_5  = 6'd5;
    localparam logic [5:0] COIN_1  = 6'd1;

    // Denomination index: 0 means "no coin"; stock array slot is index-1
    localparam logic [2:0] DENOM_NONE = 3'd0;
    localparam logic [2:0] DENOM_50   = 3'd1;
    localparam logic [2:0] DENOM_10   = 3'd2;
    localparam logic [2:0] DENOM_5    = 3'd3;
    localparam logic [2:0] DENOM_1    = 3'd4;

    localparam int NUM_DENOM = 4;

    // Map a denomination index to its coin value (0 for "no coin")
    function automatic logic [5:0] denom_value(input logic [2:0] denom);
        case (denom)
            DENOM_50: return COIN_50;
            DENOM_10: return COIN_10;
            DENOM_5:  return COIN_5;
            DENOM_1:  return COIN_1;
            default:  return 6'd0;
        endcase
    endfunction

endpackage

// File: rtl/change_dispenser_coin_select.sv
// Combinational coin chooser: picks the largest coin that still fits into
// the remaining change and is in stock. Reports DENOM_NONE when nothing fits.
module change_dispenser_coin_select
    import change_dispenser_pkg::*;
(
    input  logic [7:0] changeLeft,
    input  logic [3:0] stock50,
    input  logic [3:0] stock10,
    input  logic [3:0] stock5,
    input  logic [3:0] stock1,
    output logic [5:0] coinValue,
    output logic [2:0] denom
);

    // Greedy priority from largest to smallest denomination
    always_comb begin
        denom = DENOM_NONE;
        if (changeLeft >= {2'b00, COIN_50} && stock50 != 4'd0) begin
            denom = DENOM_50;
        end else if (changeLeft >= {2'b00, COIN_10} && stock10 != 4'd0) begin
            denom = DENOM_10;
        end else if (changeLeft >= {2'b00, COIN_5} && stock5 != 4'd0) begin
            denom = DENOM_5;
        end else if (changeLeft >= {2'b00, COIN_1} && stock1 != 4'd0) begin
            denom = DENOM_1;
        end
        coinValue = denom_value(denom);
    end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser controller. Latches the customer's money and the ticket
// cost, computes the change and ejects it one coin per cycle, largest coin
// first, while tracking a 4-bit stock counter per denomination.
module change_dispenser
    import change_dispenser_pkg::*;
#(
    parameter int unsigned STOCK_INIT = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] totalMoney,
    input  logic [7:0] costOfTicket,
    input  logic       refill,
    output logic       coinValid,
    output logic [5:0] coinOut,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [7:0] changeLeft
);

    localparam logic [3:0] STOCK_FULL = 4'(STOCK_INIT);

    state_t     state_reg;
    logic [7:0] total_reg;
    logic [7:0] cost_reg;

    // Stock slots: [0]=50, [1]=10, [2]=5, [3]=1 (slot = denom index - 1)
    logic [3:0] stock_reg  [NUM_DENOM];
    logic [3:0] stock_next [NUM_DENOM];

    logic [5:0] sel_value;
    logic [2:0] sel_denom;
    logic       take_coin;

    change_dispenser_coin_select u_coin_select (
        .changeLeft (changeLeft),
        .stock50    (stock_reg[0]),
        .stock10    (stock_reg[1]),
        .stock5     (stock_reg[2]),
        .stock1     (stock_reg[3]),
        .coinValue  (sel_value),
        .denom      (sel_denom)
    );

    // A coin leaves this cycle only from DISPENSE with change still owed
    assign take_coin = (state_reg == DISPENSE) && (changeLeft != 8'd0)
                       && (sel_denom != DENOM_NONE);

    // Per-denomination next stock: refill only while idle, otherwise
    // decrement the slot that is paying out, never going below zero
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DENOM; gi++) begin : g_stock
            assign stock_next[gi] =
                (state_reg == IDLE && refill) ? STOCK_FULL :
                (take_coin && sel_denom == 3'(gi + 1) && stock_reg[gi] != 4'd0)
                    ? stock_reg[gi] - 4'd1
                    : stock_reg[gi];
        end
    endgenerate

    // Stock counters, restored to full on reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_DENOM; i++) begin
                stock_reg[i] <= STOCK_FULL;
            end
        end else begin
            for (int i = 0; i < NUM_DENOM; i++) begin
                stock_reg[i] <= stock_next[i];
            end
        end
    end

    // Controller FSM with registered outputs. done is raised on the move
    // into DONE; error is raised while leaving ERR, so both error causes
    // report one cycle after the decision was made.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            total_reg  <= 8'd0;
            cost_reg   <= 8'd0;
            coinValid  <= 1'b0;
            coinOut    <= 6'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            changeLeft <= 8'd0;
        end else begin
            coinValid <= 1'b0;
            coinOut   <= 6'd0;
            done      <= 1'b0;
            error     <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        total_reg <= totalMoney;
                        cost_reg  <= costOfTicket;
                        busy      <= 1'b1;
                        state_reg <= CALC;
                    end
                end
                CALC: begin
                    if (total_reg < cost_reg) begin
                        changeLeft <= 8'd0;
                        busy       <= 1'b0;
                        state_reg  <= ERR;
                    end else begin
                        changeLeft <= total_reg - cost_reg;
                        state_reg  <= DISPENSE;
                    end
                end
                DISPENSE: begin
                    if (changeLeft == 8'd0) begin
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state_reg <= DONE;
                    end else if (sel_denom != DENOM_NONE) begin
                        coinValid  <= 1'b1;
                        coinOut    <= sel_value;
                        changeLeft <= changeLeft - {2'b00, sel_value};
                    end else begin
                        // Out of usable coins: keep the remainder visible
                        busy      <= 1'b0;
                        state_reg <= ERR;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                ERR: begin
                    error     <= 1'b1;
                    state_reg <= IDLE;
                end
                default: begin
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
